pc_ctrl: RTL and testbench

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/pc_ctrl_if.sv | 27 ++
 rtl/pc_ctrl.sv | 153 +++++++++++++++
 tb/tb_pc_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_if.sv
// Instruction-fetch bus between pc_ctrl (master) and instruction memory (slave).
// The request is a valid/ready handshake; the response is a single-cycle valid pulse.
interface pc_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] addr;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_data;

  modport master (
    output req_valid,
    output addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  addr,
    output req_ready,
    output resp_valid,
    output resp_data
  );
endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter / fetch sequencing controller.
// Walks BOOT -> FETCH_REQ -> FETCH_WAIT -> EXEC, looping back to FETCH_REQ when the
// execute stage reports completion, or parking in HALT on a halt request.
// Optional feature macro: PC_CTRL_MISALIGN_CHECK_EN
//   defined   : a taken redirect to a non-word-aligned target raises sticky
//               misalign_err, keeps the PC and halts.
//   undefined : the low two target bits are cleared when the redirect is loaded
//               and misalign_err stays 0.
module pc_ctrl #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h80000000)
) (
  input  logic             clk,
  input  logic             rst,
  pc_ctrl_if.master        ifu,
  output logic [WIDTH-1:0] inst,
  output logic             inst_valid,
  input  logic             exu_done,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             halt_req,
  output logic [WIDTH-1:0] pc,
  output logic             halted,
  output logic [31:0]      retired,
  output logic             misalign_err
);

  localparam logic [2:0] S_BOOT       = 3'd0;
  localparam logic [2:0] S_FETCH_REQ  = 3'd1;
  localparam logic [2:0] S_FETCH_WAIT = 3'd2;
  localparam logic [2:0] S_EXEC       = 3'd3;
  localparam logic [2:0] S_HALT       = 3'd4;

  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(32'd4);
  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

  logic [2:0]       state_q,      state_d;
  logic [WIDTH-1:0] pc_q,         pc_d;
  logic [WIDTH-1:0] inst_q,       inst_d;
  logic             inst_valid_q, inst_valid_d;
  logic [31:0]      retired_q,    retired_d;
  logic             misalign_q,   misalign_d;
  logic             req_valid_q,  req_valid_d;
  logic             halted_q,     halted_d;

  // Next-state, next-PC and retirement bookkeeping for the fetch/execute loop.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    retired_d    = retired_q;
    misalign_d   = misalign_q;

    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH_REQ;
      end

      S_FETCH_REQ: begin
        if (ifu.req_ready) begin
          state_d = S_FETCH_WAIT;
        end else begin
          state_d = S_FETCH_REQ;
        end
      end

      S_FETCH_WAIT: begin
        if (ifu.resp_valid) begin
          inst_d       = ifu.resp_data;
          inst_valid_d = 1'b1;
          state_d      = S_EXEC;
        end else begin
          state_d = S_FETCH_WAIT;
        end
      end

      S_EXEC: begin
        if (exu_done) begin
          inst_valid_d = 1'b0;
          retired_d    = retired_q + 32'd1;
          state_d      = S_FETCH_REQ;
          // Halt outranks redirect, which outranks sequential flow.
          if (halt_req) begin
            state_d = S_HALT;
          end else if (redirect_valid) begin
`ifdef PC_CTRL_MISALIGN_CHECK_EN
            if (redirect_target[1:0] != 2'b00) begin
              misalign_d = 1'b1;
              state_d    = S_HALT;
            end else begin
              pc_d = redirect_target;
            end
`else
            pc_d = redirect_target & ALIGN_MASK;
`endif
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end else begin
          state_d = S_EXEC;
        end
      end

      S_HALT: begin
        state_d      = S_HALT;
        inst_valid_d = 1'b0;
      end

      default: begin
        state_d      = S_BOOT;
        inst_valid_d = 1'b0;
      end
    endcase

    // Output flags are registered from the next state so they line up with it.
    req_valid_d = (state_d == S_FETCH_REQ);
    halted_d    = (state_d == S_HALT);
  end

  // State and output registers; reset parks the controller in BOOT at RESET_PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      retired_q    <= 32'd0;
      misalign_q   <= 1'b0;
      req_valid_q  <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      retired_q    <= retired_d;
      misalign_q   <= misalign_d;
      req_valid_q  <= req_valid_d;
      halted_q     <= halted_d;
    end
  end

  assign ifu.req_valid = req_valid_q;
  assign ifu.addr      = pc_q;
  assign inst          = inst_q;
  assign inst_valid    = inst_valid_q;
  assign pc            = pc_q;
  assign halted        = halted_q;
  assign retired       = retired_q;
  assign misalign_err  = misalign_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed vector table, hand-written corner
// sequences (halt, resets, misaligned redirect) and a randomized run checked
// against an instruction-level reference model.
module tb_pc_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic        inst_valid;
  logic        exu_done;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic [31:0] pc;
  logic        halted;
  logic [31:0] retired;
  logic        misalign_err;

  pc_ctrl_if #(.WIDTH(32)) ifu_bus ();

  pc_ctrl #(.WIDTH(32), .RESET_PC(32'h80000000)) dut (
    .clk             (clk),
    .rst             (rst),
    .ifu             (ifu_bus),
    .inst            (inst),
    .inst_valid      (inst_valid),
    .exu_done        (exu_done),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .pc              (pc),
    .halted          (halted),
    .retired         (retired),
    .misalign_err    (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural state at instruction granularity.
  logic [31:0] m_pc;
  logic [31:0] m_retired;
  logic        m_halted;
  logic        m_misalign;

  typedef struct {
    logic [31:0] data;
    int          rdly;
    int          pdly;
    int          edly;
    logic        redir;
    logic [31:0] tgt;
    logic        hlt;
    logic [31:0] exp_pc;
    logic        exp_halted;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    ifu_bus.req_ready  = 1'b0;
    ifu_bus.resp_valid = 1'b0;
    ifu_bus.resp_data  = 32'h0;
    exu_done           = 1'b0;
    redirect_valid     = 1'b0;
    redirect_target    = 32'h0;
    halt_req           = 1'b0;
  endtask

  task automatic model_reset();
    m_pc       = 32'h80000000;
    m_retired  = 32'd0;
    m_halted   = 1'b0;
    m_misalign = 1'b0;
  endtask

  // One instruction completes: apply halt > redirect > sequential rules.
  task automatic model_retire(input logic redir, input logic [31:0] tgt, input logic hlt);
    m_retired = m_retired + 32'd1;
    if (hlt) begin
      m_halted = 1'b1;
    end else if (redir) begin
`ifdef PC_CTRL_MISALIGN_CHECK_EN
      if (tgt % 4 != 0) begin
        m_misalign = 1'b1;
        m_halted   = 1'b1;
      end else begin
        m_pc = tgt;
      end
`else
      m_pc = tgt - (tgt % 4);
`endif
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Asynchronous reset mid-cycle, check reset values, release on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    clear_inputs();
    #1;
    chk("rst_pc", pc, 32'h80000000);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_req_valid", {31'd0, ifu_bus.req_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    chk("boot_no_req", {31'd0, ifu_bus.req_valid}, 32'd0);
  endtask

  // Runs one full fetch/execute of an instruction with the given delays and
  // completion inputs, injecting ignored stray inputs while waiting.
  task automatic do_instr(input logic [31:0] data, input int rdly, input int pdly,
                          input int edly, input logic redir, input logic [31:0] tgt,
                          input logic hlt);
    int n;
    n = 0;
    while (ifu_bus.req_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (ifu_bus.req_valid !== 1'b1) begin
      chk("req_timeout", {31'd0, ifu_bus.req_valid}, 32'd1);
      return;
    end
    chk("fetch_addr", ifu_bus.addr, m_pc);
    chk("fetch_pc", pc, m_pc);
    for (int k = 0; k < rdly; k++) begin
      exu_done        = 1'($urandom_range(0, 1));
      redirect_valid  = 1'($urandom_range(0, 1));
      halt_req        = 1'($urandom_range(0, 1));
      redirect_target = $urandom;
      @(negedge clk);
      chk("stall_valid", {31'd0, ifu_bus.req_valid}, 32'd1);
      chk("stall_addr", ifu_bus.addr, m_pc);
      chk("stall_retired", retired, m_retired);
    end
    clear_inputs();
    ifu_bus.req_ready = 1'b1;
    @(negedge clk);
    ifu_bus.req_ready = 1'b0;
    chk("wait_no_req", {31'd0, ifu_bus.req_valid}, 32'd0);
    for (int k = 0; k < pdly; k++) begin
      exu_done       = 1'($urandom_range(0, 1));
      redirect_valid = 1'($urandom_range(0, 1));
      halt_req       = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("wait_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("wait_pc", pc, m_pc);
      chk("wait_retired", retired, m_retired);
    end
    clear_inputs();
    ifu_bus.resp_valid = 1'b1;
    ifu_bus.resp_data  = data;
    @(negedge clk);
    clear_inputs();
    chk("exec_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("exec_inst", inst, data);
    for (int k = 0; k < edly; k++) begin
      redirect_valid     = 1'($urandom_range(0, 1));
      halt_req           = 1'($urandom_range(0, 1));
      redirect_target    = $urandom;
      ifu_bus.resp_valid = 1'($urandom_range(0, 1));
      ifu_bus.resp_data  = $urandom;
      ifu_bus.req_ready  = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("hold_inst", inst, data);
      chk("hold_inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("hold_pc", pc, m_pc);
      chk("hold_retired", retired, m_retired);
    end
    clear_inputs();
    exu_done        = 1'b1;
    redirect_valid  = redir;
    redirect_target = tgt;
    halt_req        = hlt;
    @(negedge clk);
    clear_inputs();
    model_retire(redir, tgt, hlt);
    chk("done_pc", pc, m_pc);
    chk("done_retired", retired, m_retired);
    chk("done_halted", {31'd0, halted}, {31'd0, m_halted});
    chk("done_misalign", {31'd0, misalign_err}, {31'd0, m_misalign});
    chk("done_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("done_req_valid", {31'd0, ifu_bus.req_valid}, {31'd0, !m_halted});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h00000013, 0, 0, 0, 1'b0, 32'h0,        1'b0, 32'h80000004, 1'b0};
    vecs[1] = '{32'h00100093, 5, 1, 1, 1'b0, 32'h0,        1'b0, 32'h80000008, 1'b0};
    vecs[2] = '{32'h0000006F, 1, 0, 2, 1'b1, 32'h80000100, 1'b0, 32'h80000100, 1'b0};
    vecs[3] = '{32'h1234ABCD, 0, 2, 0, 1'b1, 32'hFFFFFFFC, 1'b0, 32'hFFFFFFFC, 1'b0};
    vecs[4] = '{32'hCAFEF00D, 2, 3, 1, 1'b0, 32'h0,        1'b0, 32'h00000000, 1'b0};
    vecs[5] = '{32'h55AA55AA, 0, 1, 3, 1'b1, 32'h80000010, 1'b0, 32'h80000010, 1'b0};
    vecs[6] = '{32'h00100073, 1, 0, 2, 1'b1, 32'h80000200, 1'b1, 32'h80000010, 1'b1};

    rst = 1'b0;
    clear_inputs();
    model_reset();
    do_reset();

    // Directed table run from reset.
    for (int i = 0; i < 7; i++) begin
      do_instr(vecs[i].data, vecs[i].rdly, vecs[i].pdly, vecs[i].edly,
               vecs[i].redir, vecs[i].tgt, vecs[i].hlt);
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].exp_halted});
    end
    chk("vec_retired_total", retired, 32'd7);

    // HALT is sticky: no requests, exu_done ignored.
    for (int k = 0; k < 8; k++) begin
      exu_done          = 1'($urandom_range(0, 1));
      redirect_valid    = 1'b1;
      redirect_target   = 32'h80000400;
      ifu_bus.req_ready = 1'b1;
      @(negedge clk);
      chk("halt_no_req", {31'd0, ifu_bus.req_valid}, 32'd0);
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_pc", pc, 32'h80000010);
      chk("halt_retired", retired, 32'd7);
    end
    clear_inputs();

    // Reset pulse resumes fetch at the reset PC.
    do_reset();
    do_instr(32'h00000001, 0, 0, 0, 1'b0, 32'h0, 1'b0);
    chk("resume_retired", retired, 32'd1);

    // Reset during FETCH_WAIT; a late response during BOOT/FETCH_REQ is dropped.
    @(negedge clk);
    ifu_bus.req_ready = 1'b1;
    @(negedge clk);
    ifu_bus.req_ready = 1'b0;
    do_reset();
    ifu_bus.resp_valid = 1'b1;
    ifu_bus.resp_data  = 32'hDEADBEEF;
    @(negedge clk);
    @(negedge clk);
    clear_inputs();
    chk("stale_resp_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("stale_resp_inst", inst, 32'h0);
    chk("stale_resp_addr", ifu_bus.addr, 32'h80000000);
    do_instr(32'h0BADC0DE, 0, 0, 0, 1'b0, 32'h0, 1'b0);

    // Misaligned redirect.
    do_reset();
    do_instr(32'h00000002, 0, 0, 0, 1'b1, 32'h80000102, 1'b0);
`ifdef PC_CTRL_MISALIGN_CHECK_EN
    chk("misalign_flag", {31'd0, misalign_err}, 32'd1);
    chk("misalign_halted", {31'd0, halted}, 32'd1);
    chk("misalign_pc", pc, 32'h80000000);
`else
    chk("misalign_flag", {31'd0, misalign_err}, 32'd0);
    chk("misalign_halted", {31'd0, halted}, 32'd0);
    chk("misalign_pc", ifu_bus.addr, 32'h80000100);
`endif

    // Randomized run against the model.
    for (int i = 0; i < 150; i++) begin
      if (m_halted) begin
        do_reset();
      end else begin
        logic [31:0] tgt;
        tgt = $urandom;
        if ($urandom_range(0, 4) != 0) begin
          tgt = tgt & 32'hFFFFFFFC;
        end
        do_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0), tgt,
                 1'($urandom_range(0, 19) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
